gshare_ctrl: RTL and testbench

GSHARE_CTRL -- requirements
Module: gshare_ctrl

---
 rtl/gshare_ctrl.sv | 140 ++++++++++++++
 tb/tb_gshare_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_ctrl.sv
// Gshare branch-direction predictor: 2-bit counter table indexed by PC xor global history.
// Optional `GSHARE_FLUSH_EN adds flush_i, which clears history and re-sweeps the table.
module gshare_ctrl #(
  parameter int INDEX_WIDTH = 6,
  parameter int GHR_WIDTH   = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   lookup_valid_i,
  input  logic [31:0]            lookup_pc_i,
  output logic                   lookup_ready_o,
  output logic                   pred_valid_o,
  output logic                   pred_taken_o,
  output logic [INDEX_WIDTH-1:0] pred_index_o,
  input  logic                   update_valid_i,
  input  logic [INDEX_WIDTH-1:0] update_index_i,
  input  logic                   update_taken_i,
  output logic                   update_ready_o,
  output logic [GHR_WIDTH-1:0]   ghr_o
`ifdef GSHARE_FLUSH_EN
  ,
  input  logic                   flush_i
`endif
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_UPD_WR = 2'd2;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    else       return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
  endfunction

  logic [1:0]             state_q;
  logic [INDEX_WIDTH-1:0] sweep_q;
  logic [INDEX_WIDTH-1:0] upd_idx_p0;
  logic                   upd_taken_p0;
  logic [1:0]             upd_cnt_p0;
  logic [1:0]             tbl [ENTRIES];

  logic                   flush;
  logic                   upd_acc;
  logic                   lk_acc;
  logic [INDEX_WIDTH-1:0] ghr_ext;
  logic [INDEX_WIDTH-1:0] lk_idx;
  logic                   tbl_we;
  logic [INDEX_WIDTH-1:0] tbl_wa;
  logic [1:0]             tbl_wd;
  logic                   unused_pc;

`ifdef GSHARE_FLUSH_EN
  assign flush = flush_i && (state_q != S_INIT);
`else
  assign flush = 1'b0;
`endif

  assign unused_pc = ^{lookup_pc_i[31:INDEX_WIDTH+2], lookup_pc_i[1:0]};

  // Update has fixed priority over lookup; flush overrides both.
  assign update_ready_o = (state_q == S_IDLE) && !flush;
  assign lookup_ready_o = (state_q == S_IDLE) && !flush && !update_valid_i;
  assign upd_acc        = update_ready_o && update_valid_i;
  assign lk_acc         = lookup_ready_o && lookup_valid_i;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_WIDTH-1:0] = ghr_o;
  end

  assign lk_idx = lookup_pc_i[INDEX_WIDTH+1:2] ^ ghr_ext;

  // Single write port: either the init sweep or the update write-back.
  always_comb begin
    tbl_we = 1'b0;
    tbl_wa = sweep_q;
    tbl_wd = 2'd1;
    if (rst_i && !flush) begin
      if (state_q == S_INIT) begin
        tbl_we = 1'b1;
      end else if (state_q == S_UPD_WR) begin
        tbl_we = 1'b1;
        tbl_wa = upd_idx_p0;
        tbl_wd = sat_step(upd_cnt_p0, upd_taken_p0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (tbl_we) tbl[tbl_wa] <= tbl_wd;
  end

  // Stage p0: counter read and update capture on acceptance.
  always_ff @(posedge clk_i) begin
    if (upd_acc) begin
      upd_cnt_p0   <= tbl[update_index_i];
      upd_idx_p0   <= update_index_i;
      upd_taken_p0 <= update_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      ghr_o        <= '0;
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_index_o <= '0;
    end else if (flush) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      ghr_o        <= '0;
      pred_valid_o <= 1'b0;
    end else begin
      pred_valid_o <= lk_acc;
      if (lk_acc) begin
        pred_taken_o <= tbl[lk_idx][1];
        pred_index_o <= lk_idx;
      end
      case (state_q)
        S_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == INDEX_WIDTH'(ENTRIES - 1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (upd_acc) state_q <= S_UPD_WR;
        end
        S_UPD_WR: begin
          ghr_o   <= {ghr_o[GHR_WIDTH-2:0], upd_taken_p0};
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_ctrl.sv
// Directed bench for gshare_ctrl (default parameters); flush scenario built when GSHARE_FLUSH_EN is defined.
module tb_gshare_ctrl;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_index;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        update_ready;
  logic [5:0]  ghr;
`ifdef GSHARE_FLUSH_EN
  logic        flush;
`endif

  int errors = 0;
  int checks = 0;
  logic [5:0] ghr_exp;

  gshare_ctrl #(.INDEX_WIDTH(6), .GHR_WIDTH(6)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lookup_valid_i (lookup_valid),
    .lookup_pc_i    (lookup_pc),
    .lookup_ready_o (lookup_ready),
    .pred_valid_o   (pred_valid),
    .pred_taken_o   (pred_taken),
    .pred_index_o   (pred_index),
    .update_valid_i (update_valid),
    .update_index_i (update_index),
    .update_taken_i (update_taken),
    .update_ready_o (update_ready),
    .ghr_o          (ghr)
`ifdef GSHARE_FLUSH_EN
    ,
    .flush_i        (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_for(input logic [5:0] idx, input logic [5:0] g);
    logic [5:0] p;
    p = idx ^ g;
    return {24'd0, p, 2'b00};
  endfunction

  task automatic do_lookup(input logic [31:0] pc, output logic v, output logic t,
                           output logic [5:0] idx);
    lookup_pc = pc;
    lookup_valid = 1'b1;
    tick();
    lookup_valid = 1'b0;
    v = pred_valid;
    t = pred_taken;
    idx = pred_index;
  endtask

  task automatic do_update(input logic [5:0] idx, input logic taken);
    update_index = idx;
    update_taken = taken;
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    tick();
    ghr_exp = {ghr_exp[4:0], taken};
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (!lookup_ready && cnt < 200) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL %s: init low cycles got %0d expected 64", name, cnt);
    end
  endtask

  task automatic test_reset();
    logic v, t;
    logic [5:0] idx;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({lookup_ready, update_ready, pred_valid, pred_taken, pred_index, ghr} !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b%b pv=%b pt=%b pi=%0d ghr=%0d expected all 0",
               lookup_ready, update_ready, pred_valid, pred_taken, pred_index, ghr);
    end
    rst = 1'b1;
    ghr_exp = 6'd0;
    wait_init("reset_init");
    checks++;
    if (update_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_update_ready: got %b expected 1", update_ready);
    end
    do_lookup(32'h0000_00AC, v, t, idx);
    checks++;
    if ({v, t, idx} !== {1'b1, 1'b0, 6'h2B}) begin
      errors++;
      $display("FAIL lookup_after_reset: got v=%b t=%b idx=%0d expected v=1 t=0 idx=43", v, t, idx);
    end
  endtask

  task automatic test_lookup_basic();
    logic v, t;
    logic [5:0] idx;
    do_lookup(32'h0000_0010, v, t, idx);
    checks++;
    if ({v, t, idx} !== {1'b1, 1'b0, 6'd4}) begin
      errors++;
      $display("FAIL lookup_pc10: got v=%b t=%b idx=%0d expected v=1 t=0 idx=4", v, t, idx);
    end
    tick();
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL pred_valid_idle: got %b expected 0", pred_valid);
    end
  endtask

  task automatic test_saturation();
    logic v, t;
    logic [5:0] idx;
    logic [3:0] exp_nt;
    do_update(6'd4, 1'b1);
    do_update(6'd4, 1'b1);
    checks++;
    if (ghr !== 6'b000011) begin
      errors++;
      $display("FAIL ghr_two_taken: got %b expected 000011", ghr);
    end
    do_lookup(32'h0000_001C, v, t, idx);
    checks++;
    if ({v, t, idx} !== {1'b1, 1'b1, 6'd4}) begin
      errors++;
      $display("FAIL lookup_pc1c: got v=%b t=%b idx=%0d expected v=1 t=1 idx=4", v, t, idx);
    end
    do_update(6'd4, 1'b1);
    do_update(6'd4, 1'b1);
    checks++;
    if (ghr !== 6'b001111) begin
      errors++;
      $display("FAIL ghr_four_taken: got %b expected 001111", ghr);
    end
    // A wrapped counter would make the first not-taken prediction differ.
    exp_nt = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      do_update(6'd4, 1'b0);
      do_lookup(pc_for(6'd4, ghr_exp), v, t, idx);
      checks++;
      if ({v, t, idx, ghr} !== {1'b1, exp_nt[i], 6'd4, ghr_exp}) begin
        errors++;
        $display("FAIL nt_step%0d: got v=%b t=%b idx=%0d ghr=%b expected v=1 t=%b idx=4 ghr=%b",
                 i, v, t, idx, ghr, exp_nt[i], ghr_exp);
      end
    end
  endtask

  task automatic test_collision();
    logic [5:0] g_next;
    g_next = {ghr_exp[4:0], 1'b1};
    update_index = 6'd9;
    update_taken = 1'b1;
    update_valid = 1'b1;
    lookup_pc = pc_for(6'd9, g_next);
    lookup_valid = 1'b1;
    #1;
    checks++;
    if ({lookup_ready, update_ready} !== 2'b01) begin
      errors++;
      $display("FAIL collide_accept: got lrdy=%b urdy=%b expected 0 1", lookup_ready, update_ready);
    end
    tick();
    update_valid = 1'b0;
    ghr_exp = g_next;
    checks++;
    if ({lookup_ready, update_ready, pred_valid} !== 3'b000) begin
      errors++;
      $display("FAIL collide_updwr: got lrdy=%b urdy=%b pv=%b expected 0 0 0",
               lookup_ready, update_ready, pred_valid);
    end
    tick();
    checks++;
    if ({lookup_ready, pred_valid} !== 2'b10) begin
      errors++;
      $display("FAIL collide_idle: got lrdy=%b pv=%b expected 1 0", lookup_ready, pred_valid);
    end
    tick();
    lookup_valid = 1'b0;
    checks++;
    if ({pred_valid, pred_taken, pred_index, ghr} !== {1'b1, 1'b1, 6'd9, ghr_exp}) begin
      errors++;
      $display("FAIL collide_lookup: got pv=%b t=%b idx=%0d ghr=%b expected 1 1 9 %b",
               pred_valid, pred_taken, pred_index, ghr, ghr_exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    logic [5:0]  idxs [4];
    logic [3:0]  tk;
    pcs[0] = 32'h0000_0000;
    pcs[1] = 32'h0000_0004;
    pcs[2] = pc_for(6'd9, ghr_exp);
    pcs[3] = 32'h0000_0008;
    idxs[0] = 6'd0 ^ ghr_exp;
    idxs[1] = 6'd1 ^ ghr_exp;
    idxs[2] = 6'd9;
    idxs[3] = 6'd2 ^ ghr_exp;
    tk = 4'b0100;
    lookup_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lookup_pc = pcs[i];
      tick();
      checks++;
      if ({pred_valid, pred_taken, pred_index} !== {1'b1, tk[i], idxs[i]}) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b t=%b idx=%0d expected v=1 t=%b idx=%0d",
                 i, pred_valid, pred_taken, pred_index, tk[i], idxs[i]);
      end
    end
    lookup_valid = 1'b0;
    tick();
    checks++;
    if ({pred_valid, ghr} !== {1'b0, ghr_exp}) begin
      errors++;
      $display("FAIL b2b_end: got pv=%b ghr=%b expected 0 %b", pred_valid, ghr, ghr_exp);
    end
  endtask

  task automatic test_reset_midinit();
    logic v, t;
    logic [5:0] idx;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (20) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ghr_exp = 6'd0;
    wait_init("midinit_restart");
    checks++;
    if (ghr !== 6'd0) begin
      errors++;
      $display("FAIL midinit_ghr: got %b expected 0", ghr);
    end
    do_lookup(32'h0000_0024, v, t, idx);
    checks++;
    if ({v, t, idx} !== {1'b1, 1'b0, 6'd9}) begin
      errors++;
      $display("FAIL midinit_lookup: got v=%b t=%b idx=%0d expected v=1 t=0 idx=9", v, t, idx);
    end
  endtask

`ifdef GSHARE_FLUSH_EN
  task automatic test_flush();
    logic v, t;
    logic [5:0] idx;
    do_update(6'd5, 1'b1);
    update_index = 6'd5;
    update_taken = 1'b1;
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ghr_exp = 6'd0;
    checks++;
    if ({ghr, pred_valid, lookup_ready} !== 8'd0) begin
      errors++;
      $display("FAIL flush_state: got ghr=%b pv=%b lrdy=%b expected 0 0 0", ghr, pred_valid, lookup_ready);
    end
    wait_init("flush_init");
    do_lookup(32'h0000_0014, v, t, idx);
    checks++;
    if ({v, t, idx} !== {1'b1, 1'b0, 6'd5}) begin
      errors++;
      $display("FAIL flush_lookup: got v=%b t=%b idx=%0d expected v=1 t=0 idx=5", v, t, idx);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc = 32'd0;
    update_valid = 1'b0;
    update_index = 6'd0;
    update_taken = 1'b0;
    ghr_exp = 6'd0;
`ifdef GSHARE_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    test_reset();
    test_lookup_basic();
    test_saturation();
    test_collision();
    test_back_to_back();
    test_reset_midinit();
`ifdef GSHARE_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
